accumulator_result_reader: RTL and testbench
============================================

ACCUMULATOR_RESULT_READER -- requirements
Module: accumulator_result_reader

Interface
REQ-001 SHALL have parameter BRAM_DEPTH, default 10: result BRAM address width; frame capacity 2^BRAM_DEPTH words.
REQ-002 SHALL have parameter RES_BRAM_DATA_WIDTH, default 64: result BRAM word width.
REQ-003 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 64: stream width, equal to RES_BRAM_DATA_WIDTH.
REQ-004 SHALL have port m00_axis_aclk  in  1  sole clock.
REQ-005 SHALL have port m00_axis_aresetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  single-cycle frame request.
REQ-007 SHALL have port frame_length  in  16  words per frame, sampled on the accepted start.
REQ-008 SHALL have port result_bram_addr_read  out  BRAM_DEPTH  read address.
REQ-009 SHALL have port result_bram_r_enable  out  1  read strobe; data valid one cycle later.
REQ-010 SHALL have port result_bram_datain  in  RES_BRAM_DATA_WIDTH  read data.
REQ-011 SHALL have ports m00_axis_tvalid out 1, m00_axis_tready in 1, m00_axis_tdata out C_M00_AXIS_TDATA_WIDTH, m00_axis_tstrb out C_M00_AXIS_TDATA_WIDTH/8, m00_axis_tlast out 1: AXI-Stream master.
REQ-012 SHALL have ports busy out 1 (frame in progress) and done out 1 (one-cycle pulse at end of frame).

Function
REQ-013 SHALL implement states IDLE, STREAM, DRAIN.
- IDLE->STREAM: start=1 and frame_length!=0.
- STREAM->DRAIN: final read issued.
- DRAIN->IDLE: final beat accepted.
REQ-014 SHALL ignore start while busy, and ignore start when frame_length=0 (no beats, no done).
REQ-015 SHALL clamp frame_length above 2^BRAM_DEPTH to 2^BRAM_DEPTH.
REQ-016 SHALL read addresses 0..L-1 in ascending order, one address per enabled read; address SHALL return to 0 in IDLE.
REQ-017 SHALL latch start at edge N, drive the first read in cycle N+1, and assert tvalid for beat 0 no earlier than edge N+2.
REQ-018 SHALL buffer read data in a 2-entry skid FIFO.
- Issue a read only when (FIFO occupancy + reads in flight) < 2.
- No beat is ever lost or duplicated under any tready pattern.
REQ-019 SHALL sustain one beat per cycle while tready is held high.
REQ-020 SHALL hold tdata, tlast and tvalid stable while tvalid=1 and tready=0.
REQ-021 SHALL assert tlast only on beat L-1; tstrb SHALL be all ones whenever tvalid=1.
REQ-022 SHALL hold busy=1 from the cycle after the accepted start until the cycle after the final beat is accepted.
REQ-023 SHALL pulse done high for exactly one cycle, in the cycle after the final beat is accepted.
REQ-024 SHALL ignore a start coincident with final-beat acceptance; the next start is accepted in IDLE.

Reset
REQ-025 SHALL, while aresetn=0, asynchronously force: state IDLE, tvalid=0, tlast=0, r_enable=0, addr=0, busy=0, done=0, FIFO empty, tdata=0.
REQ-026 SHALL, on reset mid-frame, abandon the frame with no done pulse; the first start after release begins a fresh frame at address 0.

Configuration
REQ-027 SHALL, when RESULT_READER_FRAME_CNT_EN is defined, add output frame_count (32 bits).
- Reset value 0.
- Increments in the same cycle as done; wraps modulo 2^32.
REQ-028 SHALL, when RESULT_READER_FRAME_CNT_EN is undefined, omit the frame_count port and its logic; all other behaviour identical.

Structure
REQ-029 SHALL take default widths (BRAM_DEPTH, RES_BRAM_DATA_WIDTH) and state encoding from shared package accumulator_pkg.
REQ-030 SHALL implement the skid buffer as sub-module result_reader_fifo (2-entry, first-word-fall-through).

Verification
REQ-031 SHALL cover: frame_length=4, tready=1, BRAM[i]=i+0x100 -> beats 0x100..0x103 on consecutive cycles, tlast on 0x103, done one cycle later.
REQ-032 SHALL cover: frame_length=8, tready toggling 1,0,0,1 repeatedly -> 8 beats in order, no drop or duplicate, data stable during stalls.
REQ-033 SHALL cover: frame_length=0xFFFF, BRAM_DEPTH=10 -> exactly 1024 beats, addresses 0..1023, tlast on beat 1023.
REQ-034 SHALL cover: start pulsed again mid-frame and frame_length=0 start in IDLE -> both ignored, busy unchanged, no extra done.
REQ-035 SHALL cover: aresetn low after beat 2 of 6 -> tvalid=0 immediately, no done; next start streams from address 0.
REQ-036 SHALL cover: with RESULT_READER_FRAME_CNT_EN, three frames -> frame_count=3.

Source files
------------

// File: rtl/accumulator_pkg.sv
// rtl/accumulator_pkg.sv - shared defaults, state encoding and helpers for the result reader
package accumulator_pkg;

  localparam int DEF_BRAM_DEPTH          = 10;
  localparam int DEF_RES_BRAM_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } rr_state_t;

  // Limit a requested frame length to the 2^depth words the result BRAM holds.
  // The result is 17 bits wide so that a 2^16 capacity is representable.
  function automatic logic [16:0] clamp_frame_len(input logic [15:0] req, input int depth);
    logic [16:0] cap;
    cap = 17'd1 << depth;
    if ({1'b0, req} > cap) begin
      return cap;
    end
    return {1'b0, req};
  endfunction

endpackage

// File: rtl/result_reader_fifo.sv
// rtl/result_reader_fifo.sv - 2-entry first-word-fall-through skid buffer
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write one entry
//   pop               : consume the head entry
//   empty, count      : status (count is 0..2)
//   head              : head entry, valid while empty=0
module result_reader_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         empty,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/accumulator_result_reader.sv
// rtl/accumulator_result_reader.sv - streams a frame of result BRAM words out on an AXI-Stream master
//   Optional feature macro: RESULT_READER_FRAME_CNT_EN adds the 32-bit frame_count output.
//   m00_axis_aclk / m00_axis_aresetn : clock, asynchronous active-low reset
//   start, frame_length              : frame request and its length in words
//   result_bram_*                    : BRAM read port (one-cycle read latency)
//   m00_axis_*                       : AXI-Stream master
//   busy, done                       : frame in progress, end-of-frame pulse
module accumulator_result_reader
  import accumulator_pkg::*;
#(
  parameter int BRAM_DEPTH             = DEF_BRAM_DEPTH,
  parameter int RES_BRAM_DATA_WIDTH    = DEF_RES_BRAM_DATA_WIDTH,
  parameter int C_M00_AXIS_TDATA_WIDTH = DEF_RES_BRAM_DATA_WIDTH
) (
  input  logic                                m00_axis_aclk,
  input  logic                                m00_axis_aresetn,
  input  logic                                start,
  input  logic [15:0]                         frame_length,
  output logic [BRAM_DEPTH-1:0]               result_bram_addr_read,
  output logic                                result_bram_r_enable,
  input  logic [RES_BRAM_DATA_WIDTH-1:0]      result_bram_datain,
  output logic                                m00_axis_tvalid,
  input  logic                                m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  output logic                                busy,
  output logic                                done
`ifdef RESULT_READER_FRAME_CNT_EN
  ,
  output logic [31:0]                         frame_count
`endif
);

  localparam int FW = RES_BRAM_DATA_WIDTH + 1;

  rr_state_t       state_q;
  rr_state_t       state_d;
  logic [16:0]     len_q;
  logic [16:0]     rd_cnt_q;
  logic            rd_pend_q;
  logic            rd_pend_last_q;
  logic            done_q;

  logic            start_ok;
  logic            rd_issue;
  logic            rd_is_last;
  logic            beat_acc;
  logic            final_acc;
  logic [2:0]      fill_after;

  logic            fifo_empty;
  logic [1:0]      fifo_count;
  logic [FW-1:0]   fifo_head;

  assign start_ok   = (state_q == ST_IDLE) && start && (frame_length != 16'd0);
  assign beat_acc   = m00_axis_tvalid && m00_axis_tready;
  assign final_acc  = beat_acc && fifo_head[FW-1] && (state_q == ST_DRAIN);
  assign rd_is_last = (rd_cnt_q == (len_q - 17'd1));

  // Occupancy the skid buffer will have once this cycle's pop retires, plus the
  // read already in flight. Counting the pop keeps one beat per cycle with
  // tready high while still guaranteeing the returning word finds a free slot.
  assign fill_after = {1'b0, fifo_count} - {2'b00, beat_acc} + {2'b00, rd_pend_q};
  assign rd_issue   = (state_q == ST_STREAM) && (fill_after < 3'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_STREAM;
      ST_STREAM: if (rd_issue && rd_is_last) state_d = ST_DRAIN;
      ST_DRAIN:  if (final_acc) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q        <= ST_IDLE;
      len_q          <= 17'd0;
      rd_cnt_q       <= 17'd0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_pend_q      <= rd_issue;
      rd_pend_last_q <= rd_issue && rd_is_last;
      done_q         <= final_acc;
      if (start_ok) begin
        len_q <= clamp_frame_len(frame_length, BRAM_DEPTH);
      end
      // The address parks at 0 whenever the next state is IDLE so a new frame
      // always begins at word 0.
      if (state_d == ST_IDLE) begin
        rd_cnt_q <= 17'd0;
      end else if (rd_issue) begin
        rd_cnt_q <= rd_cnt_q + 17'd1;
      end
    end
  end

  // The last-beat marker travels with the data through the skid buffer.
  result_reader_fifo #(
    .W(FW)
  ) u_fifo (
    .clk       (m00_axis_aclk),
    .rst_n     (m00_axis_aresetn),
    .push      (rd_pend_q),
    .push_data ({rd_pend_last_q, result_bram_datain}),
    .pop       (beat_acc),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign result_bram_addr_read = rd_cnt_q[BRAM_DEPTH-1:0];
  assign result_bram_r_enable  = rd_issue;
  assign m00_axis_tvalid       = !fifo_empty;
  assign m00_axis_tdata        = fifo_head[RES_BRAM_DATA_WIDTH-1:0];
  assign m00_axis_tlast        = !fifo_empty && fifo_head[FW-1];
  assign m00_axis_tstrb        = '1;
  assign busy                  = (state_q != ST_IDLE);
  assign done                  = done_q;

`ifdef RESULT_READER_FRAME_CNT_EN
  logic [31:0] frame_count_q;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      frame_count_q <= 32'd0;
    end else if (final_acc) begin
      frame_count_q <= frame_count_q + 32'd1;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_accumulator_result_reader.sv
// tb/tb_accumulator_result_reader.sv - scoreboard bench for accumulator_result_reader
module tb_accumulator_result_reader;

  localparam int D  = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   frame_length = 16'd0;
  logic [D-1:0]  addr;
  logic          ren;
  logic [DW-1:0] datain = '0;
  logic          tvalid;
  logic          tready = 1'b1;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic          tlast;
  logic          busy;
  logic          done;
`ifdef RESULT_READER_FRAME_CNT_EN
  logic [31:0]   frame_count;
`endif

  accumulator_result_reader dut (
    .m00_axis_aclk         (clk),
    .m00_axis_aresetn      (rst_n),
    .start                 (start),
    .frame_length          (frame_length),
    .result_bram_addr_read (addr),
    .result_bram_r_enable  (ren),
    .result_bram_datain    (datain),
    .m00_axis_tvalid       (tvalid),
    .m00_axis_tready       (tready),
    .m00_axis_tdata        (tdata),
    .m00_axis_tstrb        (tstrb),
    .m00_axis_tlast        (tlast),
    .busy                  (busy),
    .done                  (done)
`ifdef RESULT_READER_FRAME_CNT_EN
    ,
    .frame_count           (frame_count)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] bram [0:1023];
  always @(posedge clk) begin
    if (ren) datain <= bram[addr];
  end

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    acc_cyc[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    acc_cnt = 0;
  int    done_cnt = 0;
  int    exp_addr = 0;
  int    rdy_mode = 0;
  int    rdy_idx = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        tready = 1'b1;
      end else begin
        tready = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
        rdy_idx++;
      end
    end
  end

  logic        prev_stall = 1'b0;
  logic        prev_last_acc = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_tlast = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall    = 1'b0;
      prev_last_acc = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", {63'd0, tvalid}, 64'd1);
        chk("stall_tdata", tdata, prev_data);
        chk("stall_tlast", {63'd0, tlast}, {63'd0, prev_tlast});
      end
      if (done || prev_last_acc) chk("done_timing", {63'd0, done}, {63'd0, prev_last_acc});
      if (done) done_cnt++;
      if (ren) begin
        chk("rd_addr", {54'd0, addr}, 64'(exp_addr));
        exp_addr++;
      end
      if (tvalid && tready) begin
        chk("tstrb", {56'd0, tstrb}, 64'hFF);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", tdata, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", tdata, e.data);
          chk("tlast", {63'd0, tlast}, {63'd0, e.last});
        end
        acc_cnt++;
        acc_cyc.push_back(cyc);
      end
      prev_stall    = tvalid && !tready;
      prev_data     = tdata;
      prev_tlast    = tlast;
      prev_last_acc = tvalid && tready && tlast;
    end
  end

  // Run one frame; restart_at>0 pulses a second start (length 3) that many cycles in.
  task automatic run_frame(input logic [15:0] len, input logic [63:0] base, input int mode,
                           input int restart_at);
    int n;
    int d0;
    int a0;
    bit got;
    n = (len > 16'd1024) ? 1024 : int'(len);
    for (int i = 0; i < n; i++) begin
      bram[i] = base + 64'(i);
      exp_q.push_back('{data: base + 64'(i), last: (i == n - 1)});
    end
    acc_cyc.delete();
    rdy_mode = mode;
    rdy_idx  = 0;
    exp_addr = 0;
    d0 = done_cnt;
    a0 = acc_cnt;
    @(negedge clk); #1;
    frame_length = len;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("lat_busy", {63'd0, busy}, 64'd1);
    chk("lat_ren", {63'd0, ren}, 64'd1);
    chk("lat_addr", {54'd0, addr}, 64'd0);
    chk("lat_tvalid", {63'd0, tvalid}, 64'd0);
    got = 0;
    for (int k = 1; k < 5000 && !got; k++) begin
      @(negedge clk); #1;
      if (restart_at > 0 && k == restart_at) begin
        frame_length = 16'd3;
        start = 1'b1;
      end
      if (restart_at > 0 && k == restart_at + 1) begin
        start = 1'b0;
        chk("restart_busy", {63'd0, busy}, 64'd1);
      end
      if (done_cnt != d0) begin
        got = 1;
        chk("done_busy_low", {63'd0, busy}, 64'd0);
      end
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    repeat (10) @(negedge clk);
    #1;
    chk("beat_count", 64'(acc_cnt - a0), 64'(n));
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    if (mode == 0 && acc_cyc.size() == n) begin
      chk("back_to_back", 64'(acc_cyc[n-1] - acc_cyc[0]), 64'(n - 1));
    end
    rdy_mode = 0;
  endtask

  initial begin
    int d0;
    int a0;
    bit got;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
    chk("rst_tlast", {63'd0, tlast}, 64'd0);
    chk("rst_ren", {63'd0, ren}, 64'd0);
    chk("rst_addr", {54'd0, addr}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(16'd4, 64'h100, 0, 0);
    run_frame(16'd8, 64'h200, 1, 0);
    run_frame(16'hFFFF, 64'h1000, 0, 0);
    run_frame(16'd6, 64'h400, 1, 4);

    // zero-length start in IDLE
    d0 = done_cnt;
    a0 = acc_cnt;
    @(negedge clk); #1;
    frame_length = 16'd0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("zero_busy", {63'd0, busy}, 64'd0);
    chk("zero_ren", {63'd0, ren}, 64'd0);
    repeat (10) @(negedge clk);
    #1;
    chk("zero_done", 64'(done_cnt - d0), 64'd0);
    chk("zero_beats", 64'(acc_cnt - a0), 64'd0);

    // reset in the middle of a 6-word frame
    for (int i = 0; i < 6; i++) begin
      bram[i] = 64'h500 + 64'(i);
      exp_q.push_back('{data: 64'h500 + 64'(i), last: (i == 5)});
    end
    exp_addr = 0;
    d0 = done_cnt;
    a0 = acc_cnt;
    @(negedge clk); #1;
    frame_length = 16'd6;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (acc_cnt - a0 >= 3) got = 1;
      else begin
        @(negedge clk); #1;
      end
    end
    if (!got) chk("reset_wait_timeout", 64'd0, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", {63'd0, tvalid}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_ren", {63'd0, ren}, 64'd0);
    chk("mid_rst_addr", {54'd0, addr}, 64'd0);
    chk("mid_rst_tdata", tdata, 64'd0);
`ifdef RESULT_READER_FRAME_CNT_EN
    chk("mid_rst_frame_count", {32'd0, frame_count}, 64'd0);
`endif
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("mid_rst_beats", 64'(acc_cnt - a0), 64'd3);

    run_frame(16'd4, 64'h600, 0, 0);
    run_frame(16'd1, 64'h700, 0, 0);
    run_frame(16'd2, 64'h800, 1, 0);
`ifdef RESULT_READER_FRAME_CNT_EN
    chk("frame_count", {32'd0, frame_count}, 64'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
